mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle over 32 cycles.
// A final cycle applies the sign fix-up and commits the result to hi/lo.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO writes are accepted here
// CALC  | 32 iterations of the multiply or divide datapath
// FIX   | sign correction, hi/lo commit, done pulse
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_write,
    input  logic        lo_write,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic [1:0]  op_q;
    logic [31:0] opb_q;      // multiplicand or divisor magnitude
    logic [31:0] acc_q;      // product upper word or partial remainder
    logic [31:0] mq_q;       // multiplier / product lower word, or dividend / quotient
    logic        neg_res_q;
    logic        neg_dvd_q;
    logic [4:0]  cnt_q;

    logic        load, step, commit, reg_write;

    logic        is_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] add_sum;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [63:0] prod_raw, prod_res;
    logic [31:0] quot_res, rem_res;

    // Next-state and control decode; start has priority over MTHI/MTLO in IDLE
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        reg_write = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end else begin
                    reg_write = 1'b1;
                end
            end
            CALC: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == 5'd31) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand magnitudes, per-step arithmetic and sign-corrected results
    always_comb begin
        is_signed = op[0];
        a_mag     = (is_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
        b_mag     = (is_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
        add_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : 33'd0);
        shifted   = {acc_q, mq_q[31]};
        diff      = shifted - {1'b0, opb_q};
        prod_raw  = {acc_q, mq_q};
        prod_res  = neg_res_q ? (64'd0 - prod_raw) : prod_raw;
        quot_res  = neg_res_q ? (32'd0 - mq_q) : mq_q;
        rem_res   = neg_dvd_q ? (32'd0 - acc_q) : acc_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture and iterative multiply / restoring divide datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= 2'd0;
            opb_q     <= 32'd0;
            acc_q     <= 32'd0;
            mq_q      <= 32'd0;
            neg_res_q <= 1'b0;
            neg_dvd_q <= 1'b0;
            cnt_q     <= 5'd0;
        end else if (load) begin
            op_q      <= op;
            opb_q     <= b_mag;
            acc_q     <= 32'd0;
            mq_q      <= a_mag;
            neg_res_q <= is_signed && (rs_data[31] ^ rt_data[31]);
            neg_dvd_q <= (op == 2'b11) && rs_data[31];
            cnt_q     <= 5'd0;
        end else if (step) begin
            cnt_q <= cnt_q + 5'd1;
            if (op_q[1]) begin
                // With a zero divisor no subtract ever borrows, so acc ends up
                // holding the dividend magnitude and the remainder path yields rs.
                if (!diff[32]) begin
                    acc_q <= diff[31:0];
                    mq_q  <= {mq_q[30:0], 1'b1};
                end else begin
                    acc_q <= shifted[31:0];
                    mq_q  <= {mq_q[30:0], 1'b0};
                end
            end else begin
                acc_q <= add_sum[32:1];
                mq_q  <= {add_sum[0], mq_q[31:1]};
            end
        end
    end

    // HI/LO registers and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= 32'd0;
            lo   <= 32'd0;
            done <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                if (op_q[1]) begin
                    hi <= rem_res;
                    lo <= (opb_q == 32'd0) ? 32'hFFFF_FFFF : quot_res;
                end else begin
                    hi <= prod_res[63:32];
                    lo <= prod_res[31:0];
                end
            end else if (reg_write) begin
                if (hi_write) begin
                    hi <= write_data;
                end
                if (lo_write) begin
                    lo <= write_data;
                end
            end
        end
    end

endmodule
